// File: rtl/laser_interlock_pkg.sv
// Shared types and constants for the laser fault interlock:
// FSM state encoding, fault-source bit positions and a saturating counter helper.
package laser_interlock_pkg;

  localparam int FAULT_W    = 4;
  localparam int FLT_CW     = 0;
  localparam int FLT_PEAK   = 1;
  localparam int FLT_WIDTH  = 2;
  localparam int FLT_ADC_TO = 3;

  typedef enum logic [1:0] {
    ST_ARMED    = 2'd0,
    ST_TRIPPED  = 2'd1,
    ST_CLEARING = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/pulse_timing_monitor.sv
// Timing checks on the laser pulse: over-width detection and an ADC conversion
// watchdog started by each pulse rising edge. src_o[0]=over-width, src_o[1]=adc timeout.
module pulse_timing_monitor #(
  parameter int MAX_PULSE_CYCLES   = 2000,
  parameter int ADC_TIMEOUT_CYCLES = 4000,
  parameter int CNT_W              = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       laser_pulse_i,
  input  logic       adc_data_valid_i,
  output logic [1:0] src_o
);

  localparam logic [CNT_W-1:0] WIDTH_LAST = CNT_W'(MAX_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ADC_LAST   = CNT_W'(ADC_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             pulse_q;
  logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
  logic [CNT_W-1:0] adc_cnt_q, adc_cnt_d;
  logic             adc_armed_q, adc_armed_d;
  logic             rise;
  logic             adc_timeout;

  assign rise        = laser_pulse_i & ~pulse_q;
  assign adc_timeout = adc_armed_q && (adc_cnt_q == ADC_LAST);

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    width_cnt_d = width_cnt_q;
    adc_armed_d = adc_armed_q;
    adc_cnt_d   = adc_cnt_q;

    if (!laser_pulse_i) begin
      width_cnt_d = '0;
    end else if (width_cnt_q != CNT_MAX) begin
      width_cnt_d = width_cnt_q + CNT_W'(1);
    end

    // A rise outranks a coincident valid strobe so a new pulse always restarts the watchdog.
    if (rise) begin
      adc_armed_d = 1'b1;
      adc_cnt_d   = '0;
    end else if (adc_data_valid_i || adc_timeout) begin
      adc_armed_d = 1'b0;
      adc_cnt_d   = '0;
    end else if (adc_armed_q) begin
      adc_cnt_d   = adc_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_q     <= 1'b0;
      width_cnt_q <= '0;
      adc_cnt_q   <= '0;
      adc_armed_q <= 1'b0;
    end else begin
      pulse_q     <= laser_pulse_i;
      width_cnt_q <= width_cnt_d;
      adc_cnt_q   <= adc_cnt_d;
      adc_armed_q <= adc_armed_d;
    end
  end

  assign src_o[0] = laser_pulse_i && (width_cnt_q >= WIDTH_LAST);
  assign src_o[1] = adc_timeout;

endmodule

// File: rtl/laser_fault_interlock.sv
// Sticky laser fault interlock: trips on any fault source, drops laser_enable, and
// re-arms only after a clean clear request followed by a quiet hold period.
module laser_fault_interlock
  import laser_interlock_pkg::*;
#(
  parameter int MAX_PULSE_CYCLES   = 2000,
  parameter int ADC_TIMEOUT_CYCLES = 4000,
  parameter int CLEAR_HOLD_CYCLES  = 16,
  parameter int CNT_W              = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               laser_pulse,
  input  logic               adc_data_valid,
  input  logic               cw_current_limit_fail,
  input  logic               power_peak_current_limit_fail,
  input  logic               clear_power_fail,
  output logic               laser_enable,
  output logic               fault_active,
  output logic [FAULT_W-1:0] fault_code,
  output logic [FAULT_W-1:0] first_fault,
  output logic [7:0]         trip_count
);

  localparam int                HOLD_W    = $clog2(CLEAR_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLEAR_HOLD_CYCLES - 1);

  state_e             state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [FAULT_W-1:0] fault_code_q, fault_code_d;
  logic [FAULT_W-1:0] first_fault_q, first_fault_d;
  logic [7:0]         trip_count_q, trip_count_d;
  logic               laser_enable_q, fault_active_q;
  logic [1:0]         timing_src;
  logic [FAULT_W-1:0] src;
  logic               any_src;

  pulse_timing_monitor #(
    .MAX_PULSE_CYCLES  (MAX_PULSE_CYCLES),
    .ADC_TIMEOUT_CYCLES(ADC_TIMEOUT_CYCLES),
    .CNT_W             (CNT_W)
  ) u_timing (
    .clk             (clk),
    .rst             (rst),
    .laser_pulse_i   (laser_pulse),
    .adc_data_valid_i(adc_data_valid),
    .src_o           (timing_src)
  );

  always_comb begin
    src             = '0;
    src[FLT_CW]     = cw_current_limit_fail;
    src[FLT_PEAK]   = power_peak_current_limit_fail;
    src[FLT_WIDTH]  = timing_src[0];
    src[FLT_ADC_TO] = timing_src[1];
  end

  assign any_src = |src;

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    fault_code_d  = fault_code_q;
    first_fault_d = first_fault_q;
    trip_count_d  = trip_count_q;

    unique case (state_q)
      ST_ARMED: begin
        if (any_src) begin
          state_d       = ST_TRIPPED;
          first_fault_d = src;
          fault_code_d  = src;
          trip_count_d  = sat_inc8(trip_count_q);
        end
      end
      ST_TRIPPED: begin
        fault_code_d = fault_code_q | src;
        // A clear seen while a source is active is dropped, not remembered.
        if (clear_power_fail && !any_src && !laser_pulse) begin
          state_d = ST_CLEARING;
          hold_d  = '0;
        end
      end
      ST_CLEARING: begin
        fault_code_d = fault_code_q | src;
        if (any_src || laser_pulse) begin
          state_d = ST_TRIPPED;
          hold_d  = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d       = ST_ARMED;
          hold_d        = '0;
          fault_code_d  = '0;
          first_fault_d = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_CLEARING;
        hold_d  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so laser_enable drops the cycle after a fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_CLEARING;
      hold_q         <= '0;
      fault_code_q   <= '0;
      first_fault_q  <= '0;
      trip_count_q   <= '0;
      laser_enable_q <= 1'b0;
      fault_active_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      fault_code_q   <= fault_code_d;
      first_fault_q  <= first_fault_d;
      trip_count_q   <= trip_count_d;
      laser_enable_q <= (state_d == ST_ARMED);
      fault_active_q <= (state_d != ST_ARMED);
    end
  end

  assign laser_enable = laser_enable_q;
  assign fault_active = fault_active_q;
  assign fault_code   = fault_code_q;
  assign first_fault  = first_fault_q;
  assign trip_count   = trip_count_q;

endmodule

// File: tb/tb_laser_fault_interlock.sv
// Directed self-checking bench for laser_fault_interlock using default parameters.
module tb_laser_fault_interlock;

  logic       clk = 1'b0;
  logic       rst;
  logic       laser_pulse;
  logic       adc_data_valid;
  logic       cw_fail;
  logic       peak_fail;
  logic       clear_req;
  logic       laser_enable;
  logic       fault_active;
  logic [3:0] fault_code;
  logic [3:0] first_fault;
  logic [7:0] trip_count;

  int checks = 0;
  int errors = 0;

  laser_fault_interlock dut (
    .clk                          (clk),
    .rst                          (rst),
    .laser_pulse                  (laser_pulse),
    .adc_data_valid               (adc_data_valid),
    .cw_current_limit_fail        (cw_fail),
    .power_peak_current_limit_fail(peak_fail),
    .clear_power_fail             (clear_req),
    .laser_enable                 (laser_enable),
    .fault_active                 (fault_active),
    .fault_code                   (fault_code),
    .first_fault                  (first_fault),
    .trip_count                   (trip_count)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Clear request from TRIPPED, then the 16-cycle quiet hold back to ARMED.
  task automatic clear_and_rearm(input string tag);
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    tick(15);
    check({tag, "_hold_en"}, laser_enable, 1'b0);
    tick(1);
    check({tag, "_rearm_en"}, laser_enable, 1'b1);
    check({tag, "_rearm_code"}, fault_code, 4'b0000);
    check({tag, "_rearm_first"}, first_fault, 4'b0000);
  endtask

  initial begin
    rst = 1'b1;
    laser_pulse = 1'b0;
    adc_data_valid = 1'b0;
    cw_fail = 1'b0;
    peak_fail = 1'b0;
    clear_req = 1'b0;
    tick(3);
    check("rst_en", laser_enable, 1'b0);
    check("rst_active", fault_active, 1'b1);
    check("rst_code", fault_code, 4'b0000);
    check("rst_first", first_fault, 4'b0000);
    check("rst_trips", trip_count, 8'd0);

    // Self-arm exactly 16 edges after release.
    rst = 1'b0;
    tick(15);
    check("arm15_en", laser_enable, 1'b0);
    tick(1);
    check("arm16_en", laser_enable, 1'b1);
    check("arm16_active", fault_active, 1'b0);
    check("arm16_trips", trip_count, 8'd0);

    // One-cycle CW fault.
    cw_fail = 1'b1;
    tick(1);
    cw_fail = 1'b0;
    check("cw_en", laser_enable, 1'b0);
    check("cw_active", fault_active, 1'b1);
    check("cw_first", first_fault, 4'b0001);
    check("cw_code", fault_code, 4'b0001);
    check("cw_trips", trip_count, 8'd1);
    clear_and_rearm("cw");

    // 1999-cycle pulse must not trip; valid strobe then disarms the watchdog.
    laser_pulse = 1'b1;
    tick(1999);
    check("w1999_en", laser_enable, 1'b1);
    laser_pulse = 1'b0;
    adc_data_valid = 1'b1;
    tick(1);
    adc_data_valid = 1'b0;
    tick(2);
    check("w1999_after_en", laser_enable, 1'b1);

    // 2000-cycle pulse trips on its 2000th high cycle.
    laser_pulse = 1'b1;
    tick(1999);
    check("w2000_pre_en", laser_enable, 1'b1);
    tick(1);
    check("w2000_en", laser_enable, 1'b0);
    check("w2000_code", fault_code, 4'b0100);
    check("w2000_first", first_fault, 4'b0100);
    check("w2000_trips", trip_count, 8'd2);
    laser_pulse = 1'b0;
    adc_data_valid = 1'b1;
    tick(1);
    adc_data_valid = 1'b0;
    clear_and_rearm("w2000");

    // ADC timeout: rise at cycle R, fault raised in cycle R+4000.
    laser_pulse = 1'b1;
    tick(1);
    laser_pulse = 1'b0;
    tick(3999);
    check("adc_pre_en", laser_enable, 1'b1);
    tick(1);
    check("adc_to_en", laser_enable, 1'b0);
    check("adc_to_code", fault_code, 4'b1000);
    check("adc_to_trips", trip_count, 8'd3);
    clear_and_rearm("adc");

    // Valid arriving in cycle R+3999 prevents the timeout.
    laser_pulse = 1'b1;
    tick(1);
    laser_pulse = 1'b0;
    tick(3998);
    adc_data_valid = 1'b1;
    tick(1);
    adc_data_valid = 1'b0;
    tick(10);
    check("adc_ok_en", laser_enable, 1'b1);
    check("adc_ok_trips", trip_count, 8'd3);

    // Rise coincident with valid: rise wins, watchdog still times out.
    laser_pulse = 1'b1;
    adc_data_valid = 1'b1;
    tick(1);
    laser_pulse = 1'b0;
    adc_data_valid = 1'b0;
    tick(3999);
    check("adc_race_pre_en", laser_enable, 1'b1);
    tick(1);
    check("adc_race_en", laser_enable, 1'b0);
    check("adc_race_trips", trip_count, 8'd4);
    clear_and_rearm("adc_race");

    // Peak fault; clear while fault still present is ignored and forgotten.
    peak_fail = 1'b1;
    tick(1);
    check("peak_first", first_fault, 4'b0010);
    check("peak_trips", trip_count, 8'd5);
    clear_req = 1'b1;
    tick(3);
    clear_req = 1'b0;
    peak_fail = 1'b0;
    tick(20);
    check("peak_noclear_en", laser_enable, 1'b0);
    check("peak_noclear_active", fault_active, 1'b1);

    // Enter CLEARING, fault reappears at hold count 8: back to TRIPPED, no new trip.
    clear_req = 1'b1;
    tick(1);
    clear_req = 1'b0;
    tick(8);
    peak_fail = 1'b1;
    tick(1);
    peak_fail = 1'b0;
    tick(20);
    check("reclr_en", laser_enable, 1'b0);
    check("reclr_trips", trip_count, 8'd5);
    check("reclr_first", first_fault, 4'b0010);
    clear_and_rearm("reclr");

    // Fault and clear in the same ARMED cycle: fault wins; later sources OR in.
    peak_fail = 1'b1;
    clear_req = 1'b1;
    tick(1);
    peak_fail = 1'b0;
    clear_req = 1'b0;
    check("race_en", laser_enable, 1'b0);
    check("race_trips", trip_count, 8'd6);
    cw_fail = 1'b1;
    tick(1);
    cw_fail = 1'b0;
    tick(20);
    check("race_stay_en", laser_enable, 1'b0);
    check("race_code", fault_code, 4'b0011);
    check("race_first", first_fault, 4'b0010);
    clear_and_rearm("race");

    // 300 further trips saturate the counter at 255.
    for (int i = 0; i < 300; i++) begin
      cw_fail = 1'b1;
      tick(1);
      cw_fail = 1'b0;
      clear_req = 1'b1;
      tick(1);
      clear_req = 1'b0;
      tick(16);
    end
    check("sat_trips", trip_count, 8'd255);
    check("sat_en", laser_enable, 1'b1);

    // Asynchronous reset mid-trip returns to the reset state without a clock edge.
    cw_fail = 1'b1;
    tick(1);
    cw_fail = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_trips", trip_count, 8'd0);
    check("mid_rst_code", fault_code, 4'b0000);
    check("mid_rst_first", first_fault, 4'b0000);
    check("mid_rst_active", fault_active, 1'b1);
    tick(2);
    rst = 1'b0;
    tick(5);

    // A pulse during CLEARING re-trips without counting a trip.
    laser_pulse = 1'b1;
    tick(1);
    laser_pulse = 1'b0;
    adc_data_valid = 1'b1;
    tick(1);
    adc_data_valid = 1'b0;
    tick(20);
    check("clr_pulse_en", laser_enable, 1'b0);
    check("clr_pulse_trips", trip_count, 8'd0);
    clear_and_rearm("clr_pulse");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/laser_fault_interlock.md
Name: laser_fault_interlock

Overview:
Downstream consumer of the power peak check stage. It takes the CW and peak current-limit fail flags, the laser pulse and the ADC data-valid strobe. It adds two timing checks of its own: pulse over-width and ADC conversion timeout. It latches any fault into a sticky trip state that drops laser_enable, and re-arms only after a qualified clear followed by a quiet hold period.

Parameters:
MAX_PULSE_CYCLES, 2000, laser_pulse high for this many consecutive cycles raises over-width fault
ADC_TIMEOUT_CYCLES, 4000, cycles after laser_pulse rising edge without adc_data_valid before timeout fault
CLEAR_HOLD_CYCLES, 16, consecutive quiet cycles required in CLEARING before re-arm
CNT_W, 16, width of pulse-width and timeout counters (must hold max of the two limits)

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  asynchronous, active-high reset
laser_pulse  in  1  laser drive pulse, synchronous to clk
adc_data_valid  in  1  one-cycle strobe from ADC control stage
cw_current_limit_fail  in  1  CW limit fail flag from power peak check
power_peak_current_limit_fail  in  1  peak limit fail flag from power peak check
clear_power_fail  in  1  host clear request, level, sampled each cycle
laser_enable  out  1  registered permit to laser driver; 1 only in ARMED
fault_active  out  1  1 in TRIPPED or CLEARING
fault_code  out  4  sticky OR of sources since last re-arm: [0]=cw, [1]=peak, [2]=over-width, [3]=adc timeout
first_fault  out  4  one-hot source(s) seen on the cycle of the ARMED->TRIPPED transition
trip_count  out  8  number of ARMED->TRIPPED transitions, saturates at 255

Behaviour:
- Reset (async assert, sync release): state=CLEARING; laser_enable=0; fault_active=1; fault_code=0; first_fault=0; trip_count=0; all counters 0. The block powers up disabled and self-arms after CLEAR_HOLD_CYCLES quiet cycles.
- Edge detect: registered copy of laser_pulse gives rise = laser_pulse & ~laser_pulse_d.
- Over-width counter: clears when laser_pulse=0; otherwise increments, saturating. src[2]=1 while count >= MAX_PULSE_CYCLES-1 and laser_pulse=1. A pulse of exactly MAX_PULSE_CYCLES cycles trips; MAX_PULSE_CYCLES-1 does not.
- ADC watchdog:
  - Armed flag set on rise; counter loaded to 0 on rise (a re-rise restarts it).
  - adc_data_valid clears armed flag and counter. Simultaneous rise and valid: the rise wins, so the watchdog restarts.
  - src[3]=1 when armed and count reaches ADC_TIMEOUT_CYCLES-1. The armed flag then drops, so src[3] is a one-cycle event.
- src[0]=cw_current_limit_fail, src[1]=power_peak_current_limit_fail. any_src = |src.
- FSM (registered, one-hot or encoded):
  - ARMED: laser_enable=1. If any_src -> TRIPPED next cycle; first_fault<=src; fault_code<=src; trip_count++ (saturating). Latency: source at cycle N, laser_enable=0 at N+1.
  - TRIPPED: laser_enable=0; fault_code |= src every cycle. If clear_power_fail & ~any_src & ~laser_pulse -> CLEARING, hold counter=0. A clear presented while any source is active is ignored, with no memory of it.
  - CLEARING: laser_enable=0; fault_code |= src. If any_src or laser_pulse -> TRIPPED; trip_count does not increment, first_fault unchanged. Otherwise hold counter increments; at CLEAR_HOLD_CYCLES-1 -> ARMED with fault_code<=0 and first_fault<=0.
- fault_active = (state != ARMED), registered.
- Simultaneous fault and clear: fault always wins.
- Fail inputs are consumed as already-synchronous levels from the upstream check. The upstream clear of its own flags is independent; this block never forwards clear.
- Reset mid-operation: returns to the reset state immediately; counters are discarded.

Decomposition:
- Package laser_interlock_pkg: state enum (ST_ARMED, ST_TRIPPED, ST_CLEARING); fault-bit index constants (FLT_CW=0, FLT_PEAK=1, FLT_WIDTH=2, FLT_ADC_TO=3); FAULT_W=4.
- One sub-module, pulse_timing_monitor: edge detect, over-width counter and ADC watchdog; outputs src[3:2].
- Top level holds the FSM, sticky registers and trip counter.

Test Plan:
- Reset release, all inputs 0 -> laser_enable rises exactly 16 cycles after release; fault_code=0, trip_count=0.
- ARMED, cw_current_limit_fail pulsed 1 cycle at N -> laser_enable=0 at N+1; first_fault=4'b0001; fault_code=4'b0001; trip_count=1.
- laser_pulse held 2000 cycles -> trip on the 2000th high cycle, fault_code[2]=1. A 1999-cycle pulse -> no trip.
- laser_pulse rise, no adc_data_valid for 4000 cycles -> fault_code[3]=1. Valid at cycle 3999 -> no trip.
- TRIPPED with power_peak_current_limit_fail still 1 and clear_power_fail=1 -> stays TRIPPED. Fail drops, clear asserted -> CLEARING; fail reasserts at hold count 8 -> TRIPPED, trip_count unchanged.
- Peak fail and clear asserted in the same ARMED cycle -> TRIPPED. 300 separate trips -> trip_count=255.
